// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
// Clocked multi-port register file with a per-register busy scoreboard.
// Multi-cycle producers reserve a destination at issue and release it on
// writeback. Decode uses the per-source busy flags and Stall to hold
// dependent instructions.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the write data and
// clear the busy flag on a read port when it reads the register being
// written in the same cycle. Without the macro, reads and busy flags
// reflect stored state only.
module reg_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] Destination,
    input  logic [DATA_W-1:0] Din,
    input  logic [ADDR_W-1:0] RegSource1,
    input  logic [ADDR_W-1:0] RegSource2,
    output logic [DATA_W-1:0] Source1,
    output logic [DATA_W-1:0] Source2,
    input  logic              ReserveEn,
    input  logic [ADDR_W-1:0] ReserveReg,
    output logic              ReserveOk,
    output logic              Busy1,
    output logic              Busy2,
    output logic              Stall,
    output logic [ADDR_W:0]   BusyCount
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // Architectural state
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [ADDR_W:0]   busy_count_r;

    // Decoded control
    logic              write_act_s;
    logic              release_s;
    logic              reserve_zero_s;
    logic              reserve_ok_s;
    logic              set_s;
    logic              inc_s;
    logic [DEPTH-1:0]  busy_clr_s;
    logic [DEPTH-1:0]  busy_next_s;
    logic [ADDR_W:0]   count_next_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic              busy1_s;
    logic              busy2_s;

    // Stored value at an address; the hardwired zero register always reads 0.
    function automatic logic [DATA_W-1:0] stored_value(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] value
    );
        if (ZERO_EN && (addr == ZERO_ADDR)) begin
            return {DATA_W{1'b0}};
        end else begin
            return value;
        end
    endfunction

    // Write acceptance, release and reservation decision.
    always_comb begin
        write_act_s    = WriteEn && !(ZERO_EN && (Destination == ZERO_ADDR));
        release_s      = write_act_s && busy_r[Destination];
        reserve_zero_s = ZERO_EN && (ReserveReg == ZERO_ADDR);
        // A busy register can be re-reserved when its writeback lands this cycle.
        reserve_ok_s   = ReserveEn && (reserve_zero_s || !busy_r[ReserveReg] ||
                                       (WriteEn && (Destination == ReserveReg)));
        // Reserving the zero register is accepted but tracks nothing.
        set_s          = reserve_ok_s && !reserve_zero_s;
    end

    // Next busy vector: release first, then the new reservation on top, so a
    // same-register writeback plus reserve leaves the register busy.
    always_comb begin
        busy_clr_s = busy_r;
        if (release_s) begin
            busy_clr_s[Destination] = 1'b0;
        end else begin
            busy_clr_s = busy_r;
        end
        busy_next_s = busy_clr_s;
        if (set_s) begin
            busy_next_s[ReserveReg] = 1'b1;
        end else begin
            busy_next_s = busy_clr_s;
        end
        // Counting against the post-release vector keeps the count equal to
        // the popcount when release and re-reserve hit the same register.
        inc_s = set_s && !busy_clr_s[ReserveReg];
    end

    // Busy counter next value from increment/decrement events.
    always_comb begin
        case ({inc_s, release_s})
            2'b10:   count_next_s = busy_count_r + CNT_ONE;
            2'b01:   count_next_s = busy_count_r - CNT_ONE;
            default: count_next_s = busy_count_r;
        endcase
    end

    // Data array: cleared by reset, written on accepted writes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (write_act_s) begin
            mem_r[Destination] <= Din;
        end
    end

    // Scoreboard state: busy bits and their population count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_r       <= {DEPTH{1'b0}};
            busy_count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r       <= busy_next_s;
            busy_count_r <= count_next_s;
        end
    end

    // Read ports and per-source busy flags, optionally forwarding the write.
    always_comb begin
        rd1_s   = stored_value(RegSource1, mem_r[RegSource1]);
        rd2_s   = stored_value(RegSource2, mem_r[RegSource2]);
        busy1_s = busy_r[RegSource1];
        busy2_s = busy_r[RegSource2];
`ifdef REGFILE_BYPASS_EN
        if (write_act_s && (Destination == RegSource1)) begin
            rd1_s   = Din;
            busy1_s = 1'b0;
        end else begin
            rd1_s   = stored_value(RegSource1, mem_r[RegSource1]);
            busy1_s = busy_r[RegSource1];
        end
        if (write_act_s && (Destination == RegSource2)) begin
            rd2_s   = Din;
            busy2_s = 1'b0;
        end else begin
            rd2_s   = stored_value(RegSource2, mem_r[RegSource2]);
            busy2_s = busy_r[RegSource2];
        end
`endif
    end

    assign Source1   = rd1_s;
    assign Source2   = rd2_s;
    assign Busy1     = busy1_s;
    assign Busy2     = busy2_s;
    assign Stall     = busy1_s | busy2_s;
    assign ReserveOk = reserve_ok_s;
    assign BusyCount = busy_count_r;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed self-checking bench for reg_file_scoreboard (default parameters).
// Expectations adapt to whether REGFILE_BYPASS_EN is defined.
module tb_reg_file_scoreboard;

    logic        Clk;
    logic        Reset;
    logic        WriteEn;
    logic [3:0]  Destination;
    logic [31:0] Din;
    logic [3:0]  RegSource1;
    logic [3:0]  RegSource2;
    logic [31:0] Source1;
    logic [31:0] Source2;
    logic        ReserveEn;
    logic [3:0]  ReserveReg;
    logic        ReserveOk;
    logic        Busy1;
    logic        Busy2;
    logic        Stall;
    logic [4:0]  BusyCount;

    int checks;
    int errors;

    reg_file_scoreboard #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut (
        .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Destination(Destination),
        .Din(Din), .RegSource1(RegSource1), .RegSource2(RegSource2),
        .Source1(Source1), .Source2(Source2), .ReserveEn(ReserveEn),
        .ReserveReg(ReserveReg), .ReserveOk(ReserveOk), .Busy1(Busy1),
        .Busy2(Busy2), .Stall(Stall), .BusyCount(BusyCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        WriteEn = 1'b0; ReserveEn = 1'b0;
        Destination = 4'd0; Din = 32'd0; ReserveReg = 4'd0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; idle(); RegSource1 = 4'd1; RegSource2 = 4'd2;
        ReserveEn = 1'b1; ReserveReg = 4'd9;
        #3;
        checks++;
        if (Source1 !== 32'd0 || Source2 !== 32'd0) begin
            errors++; $display("FAIL reset_src got %h %h want 0 0", Source1, Source2);
        end
        checks++;
        if (Busy1 !== 1'b0 || Busy2 !== 1'b0 || Stall !== 1'b0 || BusyCount !== 5'd0) begin
            errors++; $display("FAIL reset_busy got %b %b %b cnt %0d want 0 0 0 cnt 0",
                               Busy1, Busy2, Stall, BusyCount);
        end
        checks++;
        if (ReserveOk !== 1'b1) begin
            errors++; $display("FAIL reset_resok got %b want 1", ReserveOk);
        end
        tick();
        checks++;
        if (BusyCount !== 5'd0) begin
            errors++; $display("FAIL reset_hold_cnt got %0d want 0", BusyCount);
        end
        Reset = 1'b0; idle();
        tick();
    endtask

    task automatic test_write_read();
        WriteEn = 1'b1; Destination = 4'd1; Din = 32'h1; tick();
        Destination = 4'd2; Din = 32'h2; tick();
        idle(); RegSource1 = 4'd1; RegSource2 = 4'd2; #1;
        checks++;
        if (Source1 !== 32'h1 || Source2 !== 32'h2) begin
            errors++; $display("FAIL write_read got %h %h want 00000001 00000002", Source1, Source2);
        end
        WriteEn = 1'b1; Destination = 4'd0; Din = 32'hFFFF_FFFF; tick();
        idle(); RegSource1 = 4'd0; #1;
        checks++;
        if (Source1 !== 32'd0 || BusyCount !== 5'd0) begin
            errors++; $display("FAIL zero_reg got %h cnt %0d want 0 cnt 0", Source1, BusyCount);
        end
    endtask

    task automatic test_reserve();
        ReserveEn = 1'b1; ReserveReg = 4'd5; RegSource1 = 4'd5; RegSource2 = 4'd1; #1;
        checks++;
        if (ReserveOk !== 1'b1 || Busy1 !== 1'b0) begin
            errors++; $display("FAIL reserve_ok got ok %b busy %b want 1 0", ReserveOk, Busy1);
        end
        tick();
        checks++;
        if (Busy1 !== 1'b1 || Stall !== 1'b1 || BusyCount !== 5'd1) begin
            errors++; $display("FAIL reserve_busy got %b %b cnt %0d want 1 1 cnt 1", Busy1, Stall, BusyCount);
        end
        checks++;
        if (ReserveOk !== 1'b0) begin
            errors++; $display("FAIL reserve_again got %b want 0", ReserveOk);
        end
        tick();
        checks++;
        if (BusyCount !== 5'd1) begin
            errors++; $display("FAIL reserve_reject_cnt got %0d want 1", BusyCount);
        end
        ReserveEn = 1'b0; WriteEn = 1'b1; Destination = 4'd5; Din = 32'hABCD; #1;
`ifdef REGFILE_BYPASS_EN
        checks++;
        if (Source1 !== 32'hABCD || Busy1 !== 1'b0) begin
            errors++; $display("FAIL release_same got %h %b want 0000abcd 0", Source1, Busy1);
        end
`else
        checks++;
        if (Source1 !== 32'd0 || Busy1 !== 1'b1) begin
            errors++; $display("FAIL release_same got %h %b want 00000000 1", Source1, Busy1);
        end
`endif
        tick();
        idle(); #1;
        checks++;
        if (Busy1 !== 1'b0 || Source1 !== 32'hABCD || BusyCount !== 5'd0) begin
            errors++; $display("FAIL release got %b %h cnt %0d want 0 0000abcd cnt 0", Busy1, Source1, BusyCount);
        end
    endtask

    task automatic test_same_cycle();
        ReserveEn = 1'b1; ReserveReg = 4'd3; tick();
        WriteEn = 1'b1; Destination = 4'd3; Din = 32'h33; ReserveReg = 4'd3; #1;
        checks++;
        if (ReserveOk !== 1'b1) begin
            errors++; $display("FAIL same_reg_ok got %b want 1", ReserveOk);
        end
        tick();
        idle(); RegSource1 = 4'd3; #1;
        checks++;
        if (Busy1 !== 1'b1 || Source1 !== 32'h33 || BusyCount !== 5'd1) begin
            errors++; $display("FAIL same_reg got %b %h cnt %0d want 1 00000033 cnt 1", Busy1, Source1, BusyCount);
        end
        ReserveEn = 1'b1; ReserveReg = 4'd4; tick();
        WriteEn = 1'b1; Destination = 4'd4; Din = 32'h44; ReserveReg = 4'd6; #1;
        checks++;
        if (ReserveOk !== 1'b1 || BusyCount !== 5'd2) begin
            errors++; $display("FAIL swap_ok got %b cnt %0d want 1 cnt 2", ReserveOk, BusyCount);
        end
        tick();
        idle(); RegSource1 = 4'd4; RegSource2 = 4'd6; #1;
        checks++;
        if (Busy1 !== 1'b0 || Busy2 !== 1'b1 || BusyCount !== 5'd2 || Source1 !== 32'h44) begin
            errors++; $display("FAIL swap got %b %b cnt %0d %h want 0 1 cnt 2 00000044",
                               Busy1, Busy2, BusyCount, Source1);
        end
    endtask

    task automatic test_bypass();
        ReserveEn = 1'b1; ReserveReg = 4'd7; tick();
        idle(); WriteEn = 1'b1; Destination = 4'd7; Din = 32'h55; RegSource2 = 4'd7; #1;
`ifdef REGFILE_BYPASS_EN
        checks++;
        if (Source2 !== 32'h55 || Busy2 !== 1'b0) begin
            errors++; $display("FAIL bypass got %h %b want 00000055 0", Source2, Busy2);
        end
`else
        checks++;
        if (Source2 !== 32'd0 || Busy2 !== 1'b1) begin
            errors++; $display("FAIL no_bypass got %h %b want 00000000 1", Source2, Busy2);
        end
`endif
        tick();
        idle(); #1;
        checks++;
        if (Source2 !== 32'h55 || Busy2 !== 1'b0 || BusyCount !== 5'd2) begin
            errors++; $display("FAIL bypass_after got %h %b cnt %0d want 00000055 0 cnt 2",
                               Source2, Busy2, BusyCount);
        end
    endtask

    task automatic test_zero_reserve();
        ReserveEn = 1'b1; ReserveReg = 4'd0; RegSource1 = 4'd0; #1;
        checks++;
        if (ReserveOk !== 1'b1) begin
            errors++; $display("FAIL zero_res_ok got %b want 1", ReserveOk);
        end
        tick();
        idle(); #1;
        checks++;
        if (Busy1 !== 1'b0 || BusyCount !== 5'd2) begin
            errors++; $display("FAIL zero_res got %b cnt %0d want 0 cnt 2", Busy1, BusyCount);
        end
    endtask

    task automatic test_reset_mid();
        int ok_cnt;
        Reset = 1'b1; #2; Reset = 1'b0;
        tick();
        ok_cnt = 0;
        WriteEn = 1'b1; Destination = 4'd9; Din = 32'h99;
        for (int r = 1; r <= 15; r++) begin
            ReserveEn = 1'b1; ReserveReg = r[3:0]; #1;
            if (ReserveOk === 1'b1) ok_cnt++;
            tick();
            WriteEn = 1'b0;
        end
        idle(); RegSource1 = 4'd9; RegSource2 = 4'd15; #1;
        checks++;
        if (ok_cnt != 15 || BusyCount !== 5'd15 || Source1 !== 32'h99 || Stall !== 1'b1) begin
            errors++; $display("FAIL fill got ok %0d cnt %0d %h stall %b want 15 cnt 15 00000099 1",
                               ok_cnt, BusyCount, Source1, Stall);
        end
        #2; Reset = 1'b1; #1;
        checks++;
        if (BusyCount !== 5'd0 || Busy1 !== 1'b0 || Busy2 !== 1'b0 || Source1 !== 32'd0) begin
            errors++; $display("FAIL reset_mid got cnt %0d %b %b %h want cnt 0 0 0 0",
                               BusyCount, Busy1, Busy2, Source1);
        end
        WriteEn = 1'b1; Destination = 4'd9; Din = 32'h1234; ReserveEn = 1'b1; ReserveReg = 4'd9;
        tick();
        Reset = 1'b0; idle(); #1;
        checks++;
        if (BusyCount !== 5'd0 || Busy1 !== 1'b0 || Source1 !== 32'd0) begin
            errors++; $display("FAIL reset_edge got cnt %0d %b %h want cnt 0 0 0", BusyCount, Busy1, Source1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RegSource1 = 4'd0;
        RegSource2 = 4'd0;
        test_reset();
        test_write_read();
        test_reserve();
        test_same_cycle();
        test_bypass();
        test_zero_reserve();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
